// File: rtl/l1_req_gen_if.sv
// Request/response channel between the L1 request generator (master) and the L1 cache (slave).
// One request address per valid/ready transfer; the cache answers with a single hit/miss pulse.
interface l1_req_gen_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_hit;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_hit
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_hit
    );
endinterface

// File: rtl/l1_req_gen.sv
// Traffic generator that issues num_req L1 lookups one at a time and counts hits and misses.
// Address patterns: sequential, stride, 16-bit Galois LFSR, or repeated base address.
module l1_req_gen #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        stride,
    input  logic [CNT_W-1:0]  num_req,
    l1_req_gen_if.master      l1,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_start_d;
    logic [1:0]        r_mode;
    logic [7:0]        r_stride;
    logic [CNT_W-1:0]  r_num_req;
    logic [CNT_W-1:0]  r_issued;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;
    logic              r_req_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_start_rise;
    logic              w_load;
    logic              w_xfer;
    logic              w_resp;
    logic [ADDR_W-1:0] w_seed;
    logic [15:0]       w_lfsr_cur;
    logic [15:0]       w_lfsr_nxt;
    logic [ADDR_W-1:0] w_addr_adv;

    assign w_start_rise = start & ~r_start_d;

    // LFSR mode never seeds with zero, which would lock the register at zero.
    assign w_seed = (mode == 2'd2 && base_addr == '0) ? ADDR_W'(16'hACE1) : base_addr;

    assign w_lfsr_cur = 16'(r_addr);
    assign w_lfsr_nxt = {1'b0, w_lfsr_cur[15:1]} ^ (w_lfsr_cur[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        case (r_mode)
            2'd0:    w_addr_adv = r_addr + 1'b1;
            2'd1:    w_addr_adv = r_addr + ADDR_W'(r_stride);
            2'd2:    w_addr_adv = ADDR_W'(w_lfsr_nxt);
            default: w_addr_adv = r_addr;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_xfer      = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_rise) begin
                    w_load      = 1'b1;
                    w_state_nxt = (num_req == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (l1.req_ready) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (l1.resp_valid) begin
                    w_resp      = 1'b1;
                    w_state_nxt = (r_issued == r_num_req) ? ST_DONE : ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_d   <= 1'b0;
            r_mode      <= 2'd0;
            r_stride    <= '0;
            r_num_req   <= '0;
            r_issued    <= '0;
            r_addr      <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_req_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_start_d   <= start;
            // Status outputs are registered copies of the next state.
            r_req_valid <= (w_state_nxt == ST_ISSUE);
            r_busy      <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
            r_done      <= (w_state_nxt == ST_DONE);
            if (w_load) begin
                r_mode     <= mode;
                r_stride   <= stride;
                r_num_req  <= num_req;
                r_addr     <= w_seed;
                r_issued   <= '0;
                r_hit_cnt  <= '0;
                r_miss_cnt <= '0;
            end else begin
                if (w_xfer) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_resp) begin
                    if (l1.resp_hit) begin
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                    end else begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                    if (w_state_nxt == ST_ISSUE) begin
                        r_addr <= w_addr_adv;
                    end
                end
            end
        end
    end

    assign l1.req_valid = r_req_valid;
    assign l1.req_addr  = r_addr;
    assign hit_count    = r_hit_cnt;
    assign miss_count   = r_miss_cnt;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_l1_req_gen.sv
// Directed bench for l1_req_gen: inputs driven and outputs sampled on the falling clock edge,
// the L1 side is played by tasks answering one request at a time.
module tb_l1_req_gen;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 10;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              start     = 1'b0;
    logic [1:0]        mode      = 2'd0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [7:0]        stride    = '0;
    logic [CNT_W-1:0]  num_req   = '0;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    l1_req_gen_if #(.ADDR_W(ADDR_W)) bus ();

    l1_req_gen #(
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .base_addr (base_addr),
        .stride    (stride),
        .num_req   (num_req),
        .l1        (bus.master),
        .hit_count (hit_count),
        .miss_count(miss_count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag, input int hits, input int misses,
                                input bit exp_busy, input bit exp_done);
        check({tag, " hit_count"}, 32'(hit_count), 32'(hits));
        check({tag, " miss_count"}, 32'(miss_count), 32'(misses));
        check({tag, " busy"}, 32'(busy), 32'(exp_busy));
        check({tag, " done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"}, 32'(bus.req_valid), 32'd0);
        check({tag, " req_addr"}, 32'(bus.req_addr), 32'd0);
        check_status(tag, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic start_run(input logic [1:0] m, input logic [15:0] base,
                             input logic [7:0] strd, input logic [9:0] n);
        mode      = m;
        base_addr = base;
        stride    = strd;
        num_req   = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Wait (bounded) for a request, accept it, then answer one cycle later.
    // spur drives a hit response during the transfer cycle, which must not be counted.
    task automatic serve(input logic [15:0] exp_addr, input bit hit, input bit spur,
                         input bit chk, input string tag);
        int t = 0;
        while (!bus.req_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (chk || !bus.req_valid) check({tag, " req_valid"}, 32'(bus.req_valid), 32'd1);
        if (chk) check({tag, " req_addr"}, 32'(bus.req_addr), 32'(exp_addr));
        bus.req_ready = 1'b1;
        if (spur) begin
            bus.resp_valid = 1'b1;
            bus.resp_hit   = 1'b1;
        end
        @(negedge clk);
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        if (chk) check({tag, " one outstanding"}, 32'(bus.req_valid), 32'd0);
        bus.resp_valid = 1'b1;
        bus.resp_hit   = hit;
        @(negedge clk);
        bus.resp_valid = 1'b0;
        bus.resp_hit   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_hit   = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Sequential run: hit, miss, hit, hit.
        start_run(2'd0, 16'h0010, 8'd0, 10'd4);
        check("seq busy", 32'(busy), 32'd1);
        serve(16'h0010, 1'b1, 1'b0, 1'b1, "seq0");
        serve(16'h0011, 1'b0, 1'b0, 1'b1, "seq1");
        serve(16'h0012, 1'b1, 1'b0, 1'b1, "seq2");
        serve(16'h0013, 1'b1, 1'b0, 1'b1, "seq3");
        check_status("seq end", 3, 1, 1'b0, 1'b1);

        // Response while DONE is ignored.
        bus.resp_valid = 1'b1;
        bus.resp_hit   = 1'b1;
        repeat (2) @(negedge clk);
        bus.resp_valid = 1'b0;
        check_status("done spurious", 3, 1, 1'b0, 1'b1);

        // Stride with wrap; config changed mid-run; response during transfer ignored.
        start_run(2'd1, 16'hFFF0, 8'h20, 10'd3);
        mode    = 2'd0;
        stride  = 8'h01;
        num_req = 10'd1;
        serve(16'hFFF0, 1'b0, 1'b1, 1'b1, "str0");
        serve(16'h0010, 1'b0, 1'b1, 1'b1, "str1");
        serve(16'h0030, 1'b0, 1'b0, 1'b1, "str2");
        check_status("str end", 0, 3, 1'b0, 1'b1);

        // LFSR from zero base: seed ACE1.
        start_run(2'd2, 16'h0000, 8'd0, 10'd3);
        serve(16'hACE1, 1'b1, 1'b0, 1'b1, "lfsr0");
        serve(16'hE270, 1'b1, 1'b0, 1'b1, "lfsr1");
        serve(16'h7138, 1'b0, 1'b0, 1'b1, "lfsr2");
        check_status("lfsr end", 2, 1, 1'b0, 1'b1);

        // Backpressure on a repeat-base run.
        start_run(2'd3, 16'h1234, 8'd0, 10'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp valid held", 32'(bus.req_valid), 32'd1);
            check("bp addr held", 32'(bus.req_addr), 32'h1234);
            @(negedge clk);
        end
        serve(16'h1234, 1'b1, 1'b0, 1'b1, "bp0");
        serve(16'h1234, 1'b0, 1'b0, 1'b1, "bp1");
        check_status("bp end", 1, 1, 1'b0, 1'b1);

        // Zero-length run.
        start_run(2'd0, 16'h5555, 8'd0, 10'd0);
        check_status("zero", 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("zero no req", 32'(bus.req_valid), 32'd0);
            @(negedge clk);
        end

        // Reset asserted in WAIT.
        start_run(2'd0, 16'h0040, 8'd0, 10'd4);
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
        check("rst in wait busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post reset no req", 32'(bus.req_valid), 32'd0);
        end

        // Response pulse in IDLE is ignored.
        bus.resp_valid = 1'b1;
        bus.resp_hit   = 1'b0;
        repeat (2) @(negedge clk);
        bus.resp_valid = 1'b0;
        check_status("idle spurious", 0, 0, 1'b0, 1'b0);

        // Longest run, all misses, then a fresh run restarting the count.
        start_run(2'd3, 16'h0ABC, 8'd0, 10'd1023);
        for (int i = 0; i < 1023; i++) begin
            serve(16'h0ABC, 1'b0, 1'b0, 1'b0, "sat");
        end
        check_status("sat end", 0, 1023, 1'b0, 1'b1);
        start_run(2'd3, 16'h0ABC, 8'd0, 10'd2);
        check_status("restart", 0, 0, 1'b1, 1'b0);
        serve(16'h0ABC, 1'b0, 1'b0, 1'b1, "restart0");
        serve(16'h0ABC, 1'b0, 1'b0, 1'b1, "restart1");
        check_status("restart end", 0, 2, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l1_req_gen.md
L1_REQ_GEN -- requirements
Module: l1_req_gen

Interface
REQ-001 Parameter ADDR_W, default 16, request address width.
REQ-002 Parameter CNT_W, default 10, width of the request and statistic counters.
REQ-003 The block SHALL be clocked by clk and reset by reset; reset is asynchronous and active-high.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  async active-high reset.
- start  in  1  begins a run on a rising edge while idle.
- mode  in  2  0 sequential, 1 stride, 2 LFSR, 3 repeat-base.
- base_addr  in  ADDR_W  first address of a run.
- stride  in  8  address increment in mode 1.
- num_req  in  CNT_W  requests per run.
- req_valid  out  1  request to L1 is valid.
- req_addr  out  ADDR_W  request address.
- req_ready  in  1  L1 accepts the request.
- resp_valid  in  1  L1 lookup result is valid.
- resp_hit  in  1  result was a hit; qualified by resp_valid.
- hit_count  out  CNT_W  hits observed in current or last run.
- miss_count  out  CNT_W  misses observed in current or last run.
- busy  out  1  run in progress.
- done  out  1  last run has completed.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-006 IDLE -> ISSUE on a start rising edge (start=1 now, 0 the previous cycle) with num_req!=0. Same cycle: load address from base_addr (mode 2: seed, see REQ-010), clear both counters, clear done.
REQ-007 start rising edge with num_req==0: IDLE -> DONE directly, counters cleared, no request issued.
REQ-008 ISSUE: req_valid=1, req_addr stable. req_valid=1 and req_ready=1 in the same cycle is the transfer; then -> WAIT.
REQ-009 WAIT: resp_valid=1 increments hit_count if resp_hit=1, else miss_count.
- If requests issued == num_req: -> DONE.
- Otherwise: advance address, -> ISSUE.
- Exactly one request outstanding at any time.
REQ-010 Address advance, all modulo 2^ADDR_W (wrap, no error):
- mode 0: +1.
- mode 1: +stride, zero-extended.
- mode 2: 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, seed base_addr, or 16'hACE1 if base_addr==0.
- mode 3: unchanged.
REQ-011 mode, stride and num_req SHALL be sampled at run start; changes mid-run are ignored.
REQ-012 DONE: done=1, busy=0, counters hold. A start rising edge -> new run per REQ-006/007.
REQ-013 busy=1 exactly in ISSUE and WAIT; done=1 exactly in DONE.
REQ-014 start edges while busy are ignored.
REQ-015 resp_valid outside WAIT is ignored; no counter change.
REQ-016 resp_valid in the cycle of the request transfer is not counted; responses count only in WAIT.
REQ-017 Counters saturate at 2^CNT_W-1; they never wrap.
REQ-018 Outputs are registered; no combinational path from any input to any output.

Reset
REQ-019 On reset, outputs SHALL go immediately to:
- req_valid=0, req_addr=0.
- hit_count=0, miss_count=0.
- busy=0, done=0.
- FSM=IDLE, start-edge history=0.
REQ-020 Reset mid-run SHALL abandon the outstanding request. After release, no request issues until a new start rising edge.

Verification
REQ-021 Sequential run:
- Stimulus: mode=0, base=16'h0010, num_req=4, ready always 1, responses hit,miss,hit,hit one cycle after transfer.
- Response: addresses 0010,0011,0012,0013; hit_count=3, miss_count=1, done=1.
REQ-022 Stride wrap:
- Stimulus: mode=1, base=16'hFFF0, stride=16'h20, num_req=3.
- Response: addresses FFF0, 0010, 0030.
REQ-023 Backpressure:
- Stimulus: req_ready held 0 for 5 cycles.
- Response: req_valid=1 and req_addr stable throughout; a single transfer occurs when ready rises.
REQ-024 Zero-length and spurious response:
- Stimulus: num_req=0; separately, resp_valid pulsed in IDLE.
- Response: num_req=0 gives DONE with no req_valid and counts 0; the IDLE pulse leaves counters unchanged.
REQ-025 Reset mid-run and saturation:
- Stimulus: assert reset during WAIT; separately, mode=3 run of 1023 all-miss requests, then one more run.
- Response: reset sets all outputs to 0 asynchronously. The 1023-request run ends with miss_count=1023; each new run restarts miss_count from 0 and it never exceeds 1023.
